// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO offsets, status
// bit positions and the address decode used to pick a read/write target.
package dmem_pkg;

  localparam logic [7:0] OFF_CONSOLE_TX     = 8'h00;
  localparam logic [7:0] OFF_CONSOLE_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLE          = 8'h08;
  localparam logic [7:0] OFF_TOHOST         = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH        = 8'h10;

  localparam int STATUS_OVERFLOW_BIT = 8;
  localparam int STATUS_FULL_BIT     = 4;
  localparam int STATUS_COUNT_W      = 4;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TX,
    SEL_STATUS,
    SEL_CYCLE,
    SEL_TOHOST,
    SEL_SCRATCH,
    SEL_NONE
  } mmio_sel_t;

  // Only the word part of the page offset matters; byte lanes are ignored.
  function automatic mmio_sel_t decode_sel(input logic mmio_hit, input logic [5:0] word_off);
    mmio_sel_t sel;
    logic [7:0] off;
    off = {word_off, 2'b00};
    sel = SEL_NONE;
    if (!mmio_hit) begin
      sel = SEL_RAM;
    end else begin
      case (off)
        OFF_CONSOLE_TX:     sel = SEL_TX;
        OFF_CONSOLE_STATUS: sel = SEL_STATUS;
        OFF_CYCLE:          sel = SEL_CYCLE;
        OFF_TOHOST:         sel = SEL_TOHOST;
        OFF_SCRATCH:        sel = SEL_SCRATCH;
        default:            sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO feeding the console sink; a push into a full FIFO is accepted
// only when the head is popped on the same edge.
module console_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  output logic                     valid,
  input  logic                     ready,
  output logic [7:0]               data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = 1;
  localparam logic [PW:0]   CNT_ONE   = 1;
  localparam logic [PW:0]   CNT_DEPTH = DEPTH;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          pop;
  logic          push_ok;

  assign valid   = (cnt != '0);
  assign full    = (cnt == CNT_DEPTH);
  assign pop     = valid && ready;
  assign push_ok = push && (!full || pop);
  assign count   = cnt;
  // Gated so the head reads zero while empty, including straight after reset.
  assign data    = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO page with console FIFO,
// cycle counter, scratch register and sticky tohost/halt register.
module dmem_responder #(
  parameter int          MEM_WORDS     = 1024,
  parameter int          CONSOLE_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE     = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_write_data,
  output logic [31:0] dmem_read_data,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  import dmem_pkg::*;

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(CONSOLE_DEPTH) + 1;

  logic [31:0]   ram [MEM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          mmio_hit;
  mmio_sel_t     sel;
  logic          unused_addr_bits;

  logic [31:0]   cycle_count;
  logic [31:0]   scratch;
  logic          overflow;

  logic          fifo_push;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic [31:0]   count_ext;
  logic [STATUS_COUNT_W-1:0] count_sat;
  logic [31:0]   status_word;

  assign mmio_hit         = (dmem_addr[31:8] == MMIO_BASE[31:8]);
  assign sel              = decode_sel(mmio_hit, dmem_addr[7:2]);
  assign ram_idx          = dmem_addr[AW+1:2];
  assign unused_addr_bits = ^dmem_addr[1:0];
  assign fifo_push        = dmem_write && (sel == SEL_TX);

  console_fifo #(
    .DEPTH (CONSOLE_DEPTH)
  ) u_console_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (dmem_write_data[7:0]),
    .valid     (console_valid),
    .ready     (console_ready),
    .data      (console_data),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (dmem_write && (sel == SEL_RAM)) begin
      ram[ram_idx] <= dmem_write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      halt        <= 1'b0;
      halt_code   <= '0;
      scratch     <= '0;
      overflow    <= 1'b0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (dmem_write && (sel == SEL_TOHOST) && !halt) begin
        halt      <= 1'b1;
        halt_code <= dmem_write_data;
      end
      if (dmem_write && (sel == SEL_SCRATCH)) begin
        scratch <= dmem_write_data;
      end
      // A dropped byte is one that arrives while full with no pop to make room.
      if (dmem_write && (sel == SEL_STATUS)) begin
        overflow <= 1'b0;
      end else if (fifo_push && fifo_full && !(console_valid && console_ready)) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    count_ext = 32'(fifo_count);
    count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    status_word = '0;
    status_word[STATUS_OVERFLOW_BIT] = overflow;
    status_word[STATUS_FULL_BIT]     = fifo_full;
    status_word[STATUS_COUNT_W-1:0]  = count_sat;
  end

  always_comb begin
    dmem_read_data = '0;
    case (sel)
      SEL_RAM:     dmem_read_data = ram[ram_idx];
      SEL_STATUS:  dmem_read_data = status_word;
      SEL_CYCLE:   dmem_read_data = cycle_count;
      SEL_TOHOST:  dmem_read_data = halt_code;
      SEL_SCRATCH: dmem_read_data = scratch;
      default:     dmem_read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, console FIFO, overflow, halt,
// counter/scratch and unmapped-offset behaviour.
module tb_dmem_responder;

  localparam logic [31:0] A_TX      = 32'h8000_0000;
  localparam logic [31:0] A_STATUS  = 32'h8000_0004;
  localparam logic [31:0] A_CYCLE   = 32'h8000_0008;
  localparam logic [31:0] A_TOHOST  = 32'h8000_000C;
  localparam logic [31:0] A_SCRATCH = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_write_data;
  logic [31:0] dmem_read_data;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;
  logic        halt;
  logic [31:0] halt_code;

  int compared   = 0;
  int mismatched = 0;

  dmem_responder dut (
    .clk             (clk),
    .reset           (reset),
    .dmem_write      (dmem_write),
    .dmem_addr       (dmem_addr),
    .dmem_write_data (dmem_write_data),
    .dmem_read_data  (dmem_read_data),
    .console_valid   (console_valid),
    .console_data    (console_data),
    .console_ready   (console_ready),
    .halt            (halt),
    .halt_code       (halt_code)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    dmem_addr       = a;
    dmem_write_data = d;
    dmem_write      = 1'b1;
    @(posedge clk);
    #1;
    dmem_write      = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    dmem_addr  = a;
    dmem_write = 1'b0;
    #1;
    d = dmem_read_data;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    compared++;
    if (console_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", console_valid); end
    compared++;
    if (console_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data: got %h want 00", console_data); end
    compared++;
    if (halt !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_halt: got %b want 0", halt); end
    compared++;
    if (halt_code !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_halt_code: got %h want 0", halt_code); end
    bus_read(A_CYCLE, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_cycle: got %h want 0", r); end
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_status: got %h want 0", r); end
    bus_read(A_SCRATCH, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_scratch: got %h want 0", r); end
  endtask

  task automatic test_ram;
    logic [31:0] r;
    @(posedge clk);
    #1;
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    bus_read(32'h0000_0010, r);
    compared++;
    if (r !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL ram_read: got %h want deadbeef", r); end
    bus_read(32'h0000_1010, r);
    compared++;
    if (r !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL ram_alias: got %h want deadbeef", r); end
    bus_read(32'h0000_0013, r);
    compared++;
    if (r !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL ram_byte_offset: got %h want deadbeef", r); end
    // Same-cycle read of the word being written must see the old contents.
    dmem_addr       = 32'h0000_0010;
    dmem_write_data = 32'h1111_1111;
    dmem_write      = 1'b1;
    #1;
    compared++;
    if (dmem_read_data !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL ram_read_during_write: got %h want deadbeef", dmem_read_data); end
    @(posedge clk);
    #1;
    dmem_write = 1'b0;
    bus_read(32'h0000_0010, r);
    compared++;
    if (r !== 32'h1111_1111) begin mismatched++; $display("[TB] FAIL ram_overwrite: got %h want 11111111", r); end
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    bus_write(32'h0000_0FFC, 32'h0BAD_F00D);
    bus_read(32'h0000_1FFC, r);
    compared++;
    if (r !== 32'h0BAD_F00D) begin mismatched++; $display("[TB] FAIL ram_top_alias: got %h want 0badf00d", r); end
  endtask

  task automatic test_console_drain;
    logic [31:0] r;
    console_ready = 1'b0;
    bus_write(A_TX, 32'h0000_0048);
    bus_write(A_TX, 32'h0000_0069);
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0000_0002) begin mismatched++; $display("[TB] FAIL drain_status: got %h want 00000002", r); end
    compared++;
    if (console_valid !== 1'b1 || console_data !== 8'h48) begin mismatched++; $display("[TB] FAIL drain_head: got v=%b d=%h want v=1 d=48", console_valid, console_data); end
    bus_read(A_TX, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL tx_read_zero: got %h want 0", r); end
    console_ready = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (console_valid !== 1'b1 || console_data !== 8'h69) begin mismatched++; $display("[TB] FAIL drain_second: got v=%b d=%h want v=1 d=69", console_valid, console_data); end
    @(posedge clk);
    #1;
    compared++;
    if (console_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_empty: got v=%b want 0", console_valid); end
    console_ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [31:0] r;
    logic [7:0]  exp_seq [8];
    exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    console_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      bus_write(A_TX, 32'(i));
    end
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0000_0118) begin mismatched++; $display("[TB] FAIL ovf_status: got %h want 00000118", r); end
    compared++;
    if (console_data !== 8'h01) begin mismatched++; $display("[TB] FAIL ovf_head: got %h want 01", console_data); end
    bus_write(A_STATUS, 32'h0);
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0000_0018) begin mismatched++; $display("[TB] FAIL ovf_clear: got %h want 00000018", r); end
    // Push into a full FIFO while the head is popped on the same edge.
    dmem_addr       = A_TX;
    dmem_write_data = 32'h0000_000A;
    dmem_write      = 1'b1;
    console_ready   = 1'b1;
    @(posedge clk);
    #1;
    dmem_write    = 1'b0;
    console_ready = 1'b0;
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0000_0018) begin mismatched++; $display("[TB] FAIL full_push_pop_status: got %h want 00000018", r); end
    console_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      compared++;
      if (console_valid !== 1'b1 || console_data !== exp_seq[k]) begin
        mismatched++;
        $display("[TB] FAIL ovf_drain_%0d: got v=%b d=%h want v=1 d=%h", k, console_valid, console_data, exp_seq[k]);
      end
      @(posedge clk);
      #1;
    end
    compared++;
    if (console_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_drained: got v=%b want 0", console_valid); end
    bus_write(A_TX, 32'h0000_0055);
    compared++;
    if (console_valid !== 1'b1 || console_data !== 8'h55) begin mismatched++; $display("[TB] FAIL empty_push_pop: got v=%b d=%h want v=1 d=55", console_valid, console_data); end
    @(posedge clk);
    #1;
    compared++;
    if (console_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL empty_push_pop_drain: got v=%b want 0", console_valid); end
    console_ready = 1'b0;
  endtask

  task automatic test_halt;
    logic [31:0] r;
    bus_write(A_TOHOST, 32'h1);
    compared++;
    if (halt !== 1'b1 || halt_code !== 32'h1) begin mismatched++; $display("[TB] FAIL halt_set: got h=%b c=%h want h=1 c=1", halt, halt_code); end
    bus_write(A_TOHOST, 32'h5);
    compared++;
    if (halt_code !== 32'h1) begin mismatched++; $display("[TB] FAIL halt_sticky: got %h want 1", halt_code); end
    bus_read(A_TOHOST, r);
    compared++;
    if (r !== 32'h1) begin mismatched++; $display("[TB] FAIL tohost_read: got %h want 1", r); end
    bus_write(A_TX, 32'h0000_0077);
    compared++;
    if (console_valid !== 1'b1 || console_data !== 8'h77) begin mismatched++; $display("[TB] FAIL push_after_halt: got v=%b d=%h want v=1 d=77", console_valid, console_data); end
    #3;
    reset = 1'b0;
    #1;
    compared++;
    if (halt !== 1'b0 || halt_code !== 32'h0) begin mismatched++; $display("[TB] FAIL async_reset_halt: got h=%b c=%h want h=0 c=0", halt, halt_code); end
    compared++;
    if (console_valid !== 1'b0 || console_data !== 8'h00) begin mismatched++; $display("[TB] FAIL async_reset_fifo: got v=%b d=%h want v=0 d=00", console_valid, console_data); end
    #1;
    reset = 1'b1;
  endtask

  task automatic test_counter_scratch;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [31:0] r;
    @(posedge clk);
    #1;
    bus_read(A_CYCLE, c0);
    repeat (7) @(posedge clk);
    #1;
    bus_read(A_CYCLE, c1);
    compared++;
    if (c1 - c0 !== 32'd7) begin mismatched++; $display("[TB] FAIL cycle_delta: got %0d want 7", c1 - c0); end
    bus_write(A_CYCLE, 32'h0);
    bus_read(A_CYCLE, r);
    compared++;
    if (r !== c1 + 32'd1) begin mismatched++; $display("[TB] FAIL cycle_write_ignored: got %h want %h", r, c1 + 32'd1); end
    bus_write(A_SCRATCH, 32'hA5A5_0000);
    bus_read(A_SCRATCH, r);
    compared++;
    if (r !== 32'hA5A5_0000) begin mismatched++; $display("[TB] FAIL scratch_rw: got %h want a5a50000", r); end
    bus_read(32'h0000_0010, r);
    compared++;
    if (r !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL ram_after_scratch: got %h want deadbeef", r); end
  endtask

  task automatic test_unmapped;
    logic [31:0] r;
    bus_write(32'h0000_0040, 32'hCAFE_F00D);
    bus_write(32'h8000_0040, 32'h1234_5678);
    bus_read(32'h8000_0040, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL unmapped_read: got %h want 0", r); end
    bus_read(32'h0000_0040, r);
    compared++;
    if (r !== 32'hCAFE_F00D) begin mismatched++; $display("[TB] FAIL unmapped_ram_intact: got %h want cafef00d", r); end
    compared++;
    if (halt !== 1'b0 || console_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL unmapped_side_effect: got h=%b v=%b want h=0 v=0", halt, console_valid); end
    bus_read(A_STATUS, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL unmapped_status: got %h want 0", r); end
    bus_read(A_SCRATCH, r);
    compared++;
    if (r !== 32'hA5A5_0000) begin mismatched++; $display("[TB] FAIL unmapped_scratch: got %h want a5a50000", r); end
  endtask

  initial begin
    reset           = 1'b0;
    dmem_write      = 1'b0;
    dmem_addr       = 32'h0;
    dmem_write_data = 32'h0;
    console_ready   = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    test_ram();
    test_console_drain();
    test_overflow();
    test_halt();
    test_counter_scratch();
    test_unmapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
